// File: rtl/rat_pkg.sv
// Shared encodings for the rational multiply/divide scheduler.
package rat_pkg;

  localparam int   RAT_NREQ = 2;
  localparam logic OP_MUL   = 1'b0;
  localparam logic OP_DIV   = 1'b1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_BUSY,
    SLOT_FULL
  } slot_e;

endpackage

// File: rtl/mul_div.sv
// Rational multiply/divide datapath, one registered stage.
module mul_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             div_i,
  input  logic [WIDTH-1:0] l_num_i,
  input  logic [WIDTH-1:0] l_den_i,
  input  logic [WIDTH-1:0] r_num_i,
  input  logic [WIDTH-1:0] r_den_i,
  output logic [WIDTH-1:0] s_num_o,
  output logic [WIDTH-1:0] s_den_o
);

  logic [WIDTH-1:0] fn;
  logic [WIDTH-1:0] fd;
  logic [WIDTH-1:0] s_num_q;
  logic [WIDTH-1:0] s_den_q;

  // a/b / c/d == a*d / b*c
  always_comb begin
    fn = div_i ? r_den_i : r_num_i;
    fd = div_i ? r_num_i : r_den_i;
  end

  always_ff @(posedge clk) begin
    s_num_q <= l_num_i * fn;
    s_den_q <= l_den_i * fd;
  end

  assign s_num_o = s_num_q;
  assign s_den_o = s_den_q;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_i names the previous winner.
module rr_arb2 (
  input  logic [1:0] elig_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       last_o
);

  always_comb begin
    gnt_o  = 2'b00;
    last_o = last_i;
    case (elig_i)
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (|gnt_o) last_o = gnt_o[1];
  end

endmodule

// File: rtl/rat_md_sched.sv
// Two-requester scheduler for the shared mul_div datapath.
// Define RAT_MD_DIVZ_EN to flag divide-by-zero / zero-denominator ops.
module rat_md_sched
  import rat_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_div,
  input  logic [2*WIDTH-1:0] req_l_num,
  input  logic [2*WIDTH-1:0] req_l_den,
  input  logic [2*WIDTH-1:0] req_r_num,
  input  logic [2*WIDTH-1:0] req_r_den,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [2*WIDTH-1:0] rsp_num,
  output logic [2*WIDTH-1:0] rsp_den,
  output logic [1:0]         rsp_err
);

  slot_e            slot_q [RAT_NREQ];
  slot_e            slot_d [RAT_NREQ];
  logic             last_q;
  logic             last_d;
  logic [1:0]       elig;
  logic [1:0]       gnt;
  logic             sel;
  logic             m_div;
  logic [WIDTH-1:0] m_l_num;
  logic [WIDTH-1:0] m_l_den;
  logic [WIDTH-1:0] m_r_num;
  logic [WIDTH-1:0] m_r_den;
  logic [WIDTH-1:0] s_num;
  logic [WIDTH-1:0] s_den;
  logic             fl_v_q;
  logic             fl_tag_q;
  logic [2*WIDTH-1:0] num_q;
  logic [2*WIDTH-1:0] den_q;

  always_comb begin
    elig = '0;
    for (int i = 0; i < RAT_NREQ; i++)
      elig[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE) && !rst;
  end

  rr_arb2 u_arb (
    .elig_i (elig),
    .last_i (last_q),
    .gnt_o  (gnt),
    .last_o (last_d)
  );

  assign req_ready = gnt;
  assign sel       = gnt[1];

  always_comb begin
    m_div   = sel ? req_div[1] : req_div[0];
    m_l_num = sel ? req_l_num[2*WIDTH-1:WIDTH] : req_l_num[WIDTH-1:0];
    m_l_den = sel ? req_l_den[2*WIDTH-1:WIDTH] : req_l_den[WIDTH-1:0];
    m_r_num = sel ? req_r_num[2*WIDTH-1:WIDTH] : req_r_num[WIDTH-1:0];
    m_r_den = sel ? req_r_den[2*WIDTH-1:WIDTH] : req_r_den[WIDTH-1:0];
  end

  mul_div #(.WIDTH(WIDTH)) u_md (
    .clk     (clk),
    .div_i   (m_div == OP_DIV),
    .l_num_i (m_l_num),
    .l_den_i (m_l_den),
    .r_num_i (m_r_num),
    .r_den_i (m_r_den),
    .s_num_o (s_num),
    .s_den_o (s_den)
  );

  always_comb begin
    for (int i = 0; i < RAT_NREQ; i++) begin
      slot_d[i] = slot_q[i];
      unique case (slot_q[i])
        SLOT_IDLE: if (gnt[i]) slot_d[i] = SLOT_BUSY;
        SLOT_BUSY: if (fl_v_q && (fl_tag_q == 1'(i))) slot_d[i] = SLOT_FULL;
        SLOT_FULL: if (rsp_ready[i]) slot_d[i] = SLOT_IDLE;
        default:   slot_d[i] = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAT_NREQ; i++) slot_q[i] <= SLOT_IDLE;
      last_q   <= 1'b1;
      fl_v_q   <= 1'b0;
      fl_tag_q <= 1'b0;
      num_q    <= '0;
      den_q    <= '0;
    end else begin
      for (int i = 0; i < RAT_NREQ; i++) slot_q[i] <= slot_d[i];
      last_q   <= last_d;
      fl_v_q   <= |gnt;
      fl_tag_q <= sel;
      if (fl_v_q) begin
        if (fl_tag_q) begin
          num_q[2*WIDTH-1:WIDTH] <= s_num;
          den_q[2*WIDTH-1:WIDTH] <= s_den;
        end else begin
          num_q[WIDTH-1:0] <= s_num;
          den_q[WIDTH-1:0] <= s_den;
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < RAT_NREQ; i++)
      rsp_valid[i] = (slot_q[i] == SLOT_FULL);
  end

  assign rsp_num = num_q;
  assign rsp_den = den_q;

`ifdef RAT_MD_DIVZ_EN
  logic       iss_err;
  logic       fl_err_q;
  logic [1:0] err_q;

  always_comb begin
    iss_err = (m_div == OP_DIV) ? (m_r_num == '0)
                                : ((m_l_den == '0) || (m_r_den == '0));
  end

  // err travels with the in-flight tag, captured with the result
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_err_q <= 1'b0;
      err_q    <= '0;
    end else begin
      fl_err_q <= iss_err;
      if (fl_v_q) err_q[fl_tag_q] <= fl_err_q;
    end
  end

  assign rsp_err = err_q & rsp_valid;
`else
  assign rsp_err = '0;
`endif

endmodule

// File: tb/tb_rat_md_sched.sv
// Scoreboard bench for rat_md_sched.
`timescale 1ns/1ps
module tb_rat_md_sched;

  localparam int W = 32;
`ifdef RAT_MD_DIVZ_EN
  localparam logic EXP_DZ = 1'b1;
`else
  localparam logic EXP_DZ = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [1:0]   req_div = 2'b00;
  logic [2*W-1:0] l_num = '0, l_den = '0, r_num = '0, r_den = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b11;
  logic [2*W-1:0] rsp_num, rsp_den;
  logic [1:0]   rsp_err;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int cyc = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon_e;
  exp_t got_e;
  int gnt_log[$];
  int acc1_log[$];
  int acc_cyc[2];
  logic [1:0] prev_v = 2'b00;
  logic [1:0] outst = 2'b00;

  rat_md_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_div   (req_div),
    .req_l_num (l_num),
    .req_l_den (l_den),
    .req_r_num (r_num),
    .req_r_den (r_den),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_num   (rsp_num),
    .rsp_den   (rsp_den),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] ln, input logic [W-1:0] ld,
                                 input logic [W-1:0] rn, input logic [W-1:0] rd,
                                 input logic dv);
    exp_t e;
    logic [2*W-1:0] pn, pd;
    pn = {{W{1'b0}}, ln} * {{W{1'b0}}, (dv ? rd : rn)};
    pd = {{W{1'b0}}, ld} * {{W{1'b0}}, (dv ? rn : rd)};
    e.num = pn[W-1:0];
    e.den = pd[W-1:0];
`ifdef RAT_MD_DIVZ_EN
    e.err = dv ? (rn == '0) : ((ld == '0) || (rd == '0));
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: push on accept, pop on consume
  always @(negedge clk) begin
    if (rst) begin
      sb0.delete();
      sb1.delete();
      outst = 2'b00;
      prev_v = 2'b00;
    end else begin
      if (|req_ready) begin
        tot_cnt++;
        if (req_ready == 2'b11)
          $display("FAIL onehot_ready got=%b exp=one-hot", req_ready);
        else pass_cnt++;
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_e = model(l_num[i*W +: W], l_den[i*W +: W], r_num[i*W +: W],
                        r_den[i*W +: W], req_div[i]);
          if (i == 0) sb0.push_back(mon_e);
          else sb1.push_back(mon_e);
          gnt_log.push_back(i);
          if (i == 1) acc1_log.push_back(cyc);
          acc_cyc[i] = cyc;
          tot_cnt++;
          if (outst[i])
            $display("FAIL grant_busy req%0d got=granted exp=not granted", i);
          else pass_cnt++;
          outst[i] = 1'b1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && !prev_v[i]) begin
          tot_cnt++;
          if (cyc - acc_cyc[i] != 2)
            $display("FAIL latency req%0d got=%0d exp=2", i, cyc - acc_cyc[i]);
          else pass_cnt++;
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          tot_cnt++;
          if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
            $display("FAIL unexpected_rsp req%0d got=rsp exp=none", i);
          end else begin
            mon_e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            got_e = {rsp_num[i*W +: W], rsp_den[i*W +: W], rsp_err[i]};
            if (got_e !== mon_e)
              $display("FAIL sb_rsp req%0d got=%h/%h e%b exp=%h/%h e%b", i,
                       got_e.num, got_e.den, got_e.err, mon_e.num, mon_e.den, mon_e.err);
            else pass_cnt++;
          end
          outst[i] = 1'b0;
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] ln, input logic [W-1:0] ld,
                         input logic [W-1:0] rn, input logic [W-1:0] rd, input logic dv);
    l_num[i*W +: W] = ln;
    l_den[i*W +: W] = ld;
    r_num[i*W +: W] = rn;
    r_den[i*W +: W] = rd;
    req_div[i] = dv;
  endtask

  task automatic wait_rsp(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tot_cnt++;
    if (req_ready !== 2'b00) $display("FAIL rst_ready got=%b exp=00", req_ready);
    else pass_cnt++;
    tot_cnt++;
    if (rsp_valid !== 2'b00) $display("FAIL rst_valid got=%b exp=00", rsp_valid);
    else pass_cnt++;
    tot_cnt++;
    if (rsp_num !== '0 || rsp_den !== '0)
      $display("FAIL rst_data got=%h/%h exp=0/0", rsp_num, rsp_den);
    else pass_cnt++;
    tot_cnt++;
    if (rsp_err !== 2'b00) $display("FAIL rst_err got=%b exp=00", rsp_err);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    tot_cnt++;
    if (rsp_valid !== 2'b00) $display("FAIL post_rst_valid got=%b exp=00", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic single(input string nm, input int i, input logic [W-1:0] ln,
                        input logic [W-1:0] ld, input logic [W-1:0] rn,
                        input logic [W-1:0] rd, input logic dv,
                        input logic [W-1:0] en, input logic [W-1:0] ed, input logic ee);
    bit ok;
    logic [1:0] want;
    want = (i == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    set_req(i, ln, ld, rn, rd, dv);
    req_valid = want;
    @(negedge clk);
    tot_cnt++;
    if (req_ready !== want) $display("FAIL %s_accept got=%b exp=%b", nm, req_ready, want);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(i, ok);
    tot_cnt++;
    if (!ok) $display("FAIL %s_timeout got=no rsp exp=rsp", nm);
    else pass_cnt++;
    tot_cnt++;
    if (rsp_num[i*W +: W] !== en || rsp_den[i*W +: W] !== ed || rsp_err[i] !== ee)
      $display("FAIL %s_data got=%0d/%0d e%b exp=%0d/%0d e%b", nm,
               rsp_num[i*W +: W], rsp_den[i*W +: W], rsp_err[i], en, ed, ee);
    else pass_cnt++;
  endtask

  task automatic test_single_mul;
    single("mul", 0, 3, 4, 5, 7, 1'b0, 15, 28, 1'b0);
  endtask

  task automatic test_single_div;
    single("div", 1, 2, 3, 4, 5, 1'b1, 10, 12, 1'b0);
  endtask

  task automatic test_overflow;
    single("ovf", 0, 32'h10000, 1, 32'h10000, 1, 1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_divz;
    single("divz", 1, 5, 6, 0, 7, 1'b1, 35, 0, EXP_DZ);
  endtask

  task automatic test_contention;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    gnt_log.delete();
    rst = 1'b0;
    rsp_ready = 2'b11;
    set_req(0, 11, 13, 17, 19, 1'b0);
    set_req(1, 23, 29, 31, 37, 1'b1);
    req_valid = 2'b11;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    tot_cnt++;
    if (gnt_log.size() != 6) $display("FAIL cont_count got=%0d exp=6", gnt_log.size());
    else pass_cnt++;
    for (int k = 0; k < gnt_log.size() && k < 6; k++) begin
      tot_cnt++;
      if (gnt_log[k] != (k % 2))
        $display("FAIL cont_order[%0d] got=%0d exp=%0d", k, gnt_log[k], k % 2);
      else pass_cnt++;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [W-1:0] hn, hd;
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    set_req(0, 9, 2, 7, 3, 1'b0);
    set_req(1, 4, 5, 6, 7, 1'b1);
    req_valid = 2'b11;
    wait_rsp(0, ok);
    tot_cnt++;
    if (!ok) $display("FAIL bp_timeout got=no rsp exp=rsp");
    else pass_cnt++;
    hn = rsp_num[W-1:0];
    hd = rsp_den[W-1:0];
    @(posedge clk); #1;
    acc1_log.delete();
    repeat (9) begin
      @(negedge clk);
      tot_cnt++;
      if (rsp_valid[0] !== 1'b1 || rsp_num[W-1:0] !== hn || rsp_den[W-1:0] !== hd)
        $display("FAIL bp_hold got=v%b %0d/%0d exp=v1 %0d/%0d",
                 rsp_valid[0], rsp_num[W-1:0], rsp_den[W-1:0], hn, hd);
      else pass_cnt++;
      tot_cnt++;
      if (req_ready[0] !== 1'b0) $display("FAIL bp_ready0 got=%b exp=0", req_ready[0]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (acc1_log.size() < 3) $display("FAIL bp_req1_count got=%0d exp=3", acc1_log.size());
    else pass_cnt++;
    for (int k = 1; k < acc1_log.size(); k++) begin
      tot_cnt++;
      if (acc1_log[k] - acc1_log[k-1] != 3)
        $display("FAIL bp_req1_rate got=%0d exp=3", acc1_log[k] - acc1_log[k-1]);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    req_valid = 2'b00;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset_midop;
    @(posedge clk); #1;
    set_req(0, 3, 4, 5, 7, 1'b0);
    set_req(1, 2, 3, 4, 5, 1'b1);
    req_valid = 2'b01;
    @(negedge clk);
    tot_cnt++;
    if (req_ready !== 2'b01) $display("FAIL midop_accept got=%b exp=01", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tot_cnt++;
      if (rsp_valid !== 2'b00) $display("FAIL midop_valid got=%b exp=00", rsp_valid);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    tot_cnt++;
    if (req_ready !== 2'b01) $display("FAIL midop_tie got=%b exp=01", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_single_div();
    test_overflow();
    test_divz();
    test_contention();
    test_backpressure();
    test_reset_midop();
    @(negedge clk);
    tot_cnt++;
    if (sb0.size() != 0 || sb1.size() != 0)
      $display("FAIL sb_drain got=%0d/%0d exp=0/0", sb0.size(), sb1.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
